pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides which pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) advance, hold, or take a bubble. Three events drive it: load-use hazards detected in ID, branches taken in ID, and data-memory accesses in MEM that wait on a ready handshake. It also keeps stall statistics and raises a sticky error when a memory access times out.

---
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory-wait stalls,
// load-use bubbles and branch flushes, and keeps stall statistics plus a sticky timeout flag.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IFID_RS_i,
    input  logic [4:0]  IFID_RT_i,
    input  logic        IFID_UsesRT_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RT_i,
    input  logic        Branch_i,
    input  logic        EXMEM_MemAccess_i,
    input  logic        MemReady_i,
    output logic        PCWrite_o,
    output logic        IFID_Write_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Write_o,
    output logic        IDEX_Bubble_o,
    output logic        EXMEM_Write_o,
    output logic        MEMWB_Bubble_o,
    output logic        MemReq_o,
    output logic [15:0] StallCycles_o,
    output logic        Error_o
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [15:0] wcnt_reg, wcnt_next;
    logic [15:0] stall_cnt_reg;
    logic        error_reg, error_next;
    logic        load_use;

    assign load_use = IDEX_MemRead_i && (IDEX_RT_i != 5'd0) &&
                      ((IDEX_RT_i == IFID_RS_i) ||
                       (IFID_UsesRT_i && (IDEX_RT_i == IFID_RT_i)));

    always_comb begin
        PCWrite_o      = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Write_o   = 1'b1;
        IDEX_Bubble_o  = 1'b0;
        EXMEM_Write_o  = 1'b1;
        MEMWB_Bubble_o = 1'b0;
        MemReq_o       = 1'b0;
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        error_next     = error_reg;

        // Reset forces quiet outputs; the register block handles the state.
        if (!rst_i) begin
            case (state_reg)
                RUN: begin
                    MemReq_o = EXMEM_MemAccess_i;
                    if (EXMEM_MemAccess_i && !MemReady_i) begin
                        PCWrite_o      = 1'b0;
                        IFID_Write_o   = 1'b0;
                        IDEX_Write_o   = 1'b0;
                        EXMEM_Write_o  = 1'b0;
                        MEMWB_Bubble_o = 1'b1;
                        state_next     = MEM_WAIT;
                        wcnt_next      = 16'd1;
                    end else if (load_use) begin
                        PCWrite_o     = 1'b0;
                        IFID_Write_o  = 1'b0;
                        IDEX_Bubble_o = 1'b1;
                    end else if (Branch_i) begin
                        IFID_Flush_o = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    MemReq_o = 1'b1;
                    if (MemReady_i) begin
                        state_next = RUN;
                        wcnt_next  = 16'd0;
                    end else if (wcnt_reg == TIMEOUT_CNT) begin
                        // Abort: release the pipeline but discard the access result.
                        MemReq_o       = 1'b0;
                        MEMWB_Bubble_o = 1'b1;
                        error_next     = 1'b1;
                        state_next     = RUN;
                        wcnt_next      = 16'd0;
                    end else begin
                        PCWrite_o      = 1'b0;
                        IFID_Write_o   = 1'b0;
                        IDEX_Write_o   = 1'b0;
                        EXMEM_Write_o  = 1'b0;
                        MEMWB_Bubble_o = 1'b1;
                        wcnt_next      = wcnt_reg + 16'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            wcnt_reg      <= 16'd0;
            stall_cnt_reg <= 16'd0;
            error_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            error_reg <= error_next;
            if (!PCWrite_o && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign StallCycles_o = stall_cnt_reg;
    assign Error_o       = error_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, load-use, memory hit/miss, priority,
// branch flush and timeout, each with hand-computed expected outputs.
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  IFID_RS_i, IFID_RT_i, IDEX_RT_i;
    logic        IFID_UsesRT_i, IDEX_MemRead_i, Branch_i;
    logic        EXMEM_MemAccess_i, MemReady_i;
    logic        PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o;
    logic        IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o, MemReq_o;
    logic [15:0] StallCycles_o;
    logic        Error_o;

    int checks = 0;
    int failures = 0;

    // Output vector order: PCW IFW FLUSH IDW IDBUB EXW MWBBUB REQ
    logic [7:0] outs;
    localparam logic [7:0] O_DEF    = 8'b1101_0100;
    localparam logic [7:0] O_HIT    = 8'b1101_0101;
    localparam logic [7:0] O_MSTALL = 8'b0000_0011;
    localparam logic [7:0] O_LDUSE  = 8'b0001_1100;
    localparam logic [7:0] O_BRANCH = 8'b1111_0100;
    localparam logic [7:0] O_ABORT  = 8'b1101_0110;

    assign outs = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o,
                   IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o, MemReq_o};

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .IFID_RS_i         (IFID_RS_i),
        .IFID_RT_i         (IFID_RT_i),
        .IFID_UsesRT_i     (IFID_UsesRT_i),
        .IDEX_MemRead_i    (IDEX_MemRead_i),
        .IDEX_RT_i         (IDEX_RT_i),
        .Branch_i          (Branch_i),
        .EXMEM_MemAccess_i (EXMEM_MemAccess_i),
        .MemReady_i        (MemReady_i),
        .PCWrite_o         (PCWrite_o),
        .IFID_Write_o      (IFID_Write_o),
        .IFID_Flush_o      (IFID_Flush_o),
        .IDEX_Write_o      (IDEX_Write_o),
        .IDEX_Bubble_o     (IDEX_Bubble_o),
        .EXMEM_Write_o     (EXMEM_Write_o),
        .MEMWB_Bubble_o    (MEMWB_Bubble_o),
        .MemReq_o          (MemReq_o),
        .StallCycles_o     (StallCycles_o),
        .Error_o           (Error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    // Combinational outputs are checked mid-cycle, then the edge is taken.
    task automatic check_outs(input string tag, input logic [7:0] exp);
        @(negedge clk_i);
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_quiet();
        IFID_RS_i = 5'd0; IFID_RT_i = 5'd0; IFID_UsesRT_i = 1'b0;
        IDEX_MemRead_i = 1'b0; IDEX_RT_i = 5'd0; Branch_i = 1'b0;
        EXMEM_MemAccess_i = 1'b0; MemReady_i = 1'b0;
    endtask

    initial begin
        set_quiet();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_stall", 32'(StallCycles_o), 32'd0);
        check("rst_err", 32'(Error_o), 32'd0);

        // Enter MEM_WAIT, then reset for two cycles in the middle of it
        EXMEM_MemAccess_i = 1'b1; MemReady_i = 1'b0;
        check_outs("pre_rst_miss", O_MSTALL);
        check_outs("pre_rst_wait", O_MSTALL);
        rst_i = 1'b1;
        check_outs("in_rst_forced", O_DEF);
        check_outs("in_rst_forced2", O_DEF);
        rst_i = 1'b0;
        set_quiet();
        check("post_rst_stall", 32'(StallCycles_o), 32'd0);
        check("post_rst_err", 32'(Error_o), 32'd0);

        // Load-use on rs; a MEM_WAIT leftover would show memory-stall outputs instead
        IDEX_MemRead_i = 1'b1; IDEX_RT_i = 5'd5; IFID_RS_i = 5'd5;
        check_outs("lduse_rs", O_LDUSE);
        IDEX_MemRead_i = 1'b0;
        check_outs("lduse_after", O_DEF);
        check("lduse_stall", 32'(StallCycles_o), 32'd1);
        IDEX_MemRead_i = 1'b1; IDEX_RT_i = 5'd0; IFID_RS_i = 5'd0;
        check_outs("lduse_r0", O_DEF);
        check("lduse_r0_stall", 32'(StallCycles_o), 32'd1);
        IDEX_RT_i = 5'd7; IFID_RS_i = 5'd3; IFID_RT_i = 5'd7; IFID_UsesRT_i = 1'b1;
        check_outs("lduse_rt", O_LDUSE);
        IFID_UsesRT_i = 1'b0;
        check_outs("lduse_rt_unused", O_DEF);
        check("lduse_rt_stall", 32'(StallCycles_o), 32'd2);
        set_quiet();

        // Memory hit: request with no stall
        EXMEM_MemAccess_i = 1'b1; MemReady_i = 1'b1;
        check_outs("mem_hit", O_HIT);
        check("mem_hit_stall", 32'(StallCycles_o), 32'd2);

        // Miss: ready low for 3 cycles, high on the 4th
        MemReady_i = 1'b0;
        for (int i = 0; i < 3; i++) check_outs($sformatf("miss_c%0d", i), O_MSTALL);
        MemReady_i = 1'b1;
        check_outs("miss_ready", O_HIT);
        check("miss_stall", 32'(StallCycles_o), 32'd5);
        set_quiet();
        check_outs("miss_back_run", O_DEF);

        // Priority: miss + load-use + branch together
        EXMEM_MemAccess_i = 1'b1; MemReady_i = 1'b0;
        IDEX_MemRead_i = 1'b1; IDEX_RT_i = 5'd5; IFID_RS_i = 5'd5; Branch_i = 1'b1;
        check_outs("prio_miss", O_MSTALL);
        MemReady_i = 1'b1;
        check_outs("prio_ready", O_HIT);
        check("prio_stall", 32'(StallCycles_o), 32'd6);
        set_quiet();

        // Branch flush without hazards
        Branch_i = 1'b1;
        check_outs("branch", O_BRANCH);
        Branch_i = 1'b0;
        check_outs("branch_after", O_DEF);
        check("branch_stall", 32'(StallCycles_o), 32'd6);

        // Timeout with TIMEOUT=4: 4 stall cycles, then the abort cycle
        EXMEM_MemAccess_i = 1'b1; MemReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_outs($sformatf("tmo_stall%0d", i), O_MSTALL);
            check($sformatf("tmo_err_low%0d", i), 32'(Error_o), 32'd0);
        end
        check_outs("tmo_abort", O_ABORT);
        check("tmo_err_set", 32'(Error_o), 32'd1);
        check("tmo_stall_cnt", 32'(StallCycles_o), 32'd10);
        EXMEM_MemAccess_i = 1'b0;
        check_outs("tmo_back_run", O_DEF);
        repeat (3) @(posedge clk_i);
        #1;
        check("tmo_err_sticky", 32'(Error_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("tmo_err_cleared", 32'(Error_o), 32'd0);
        check("tmo_stall_cleared", 32'(StallCycles_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
